// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file storage stage.
//   DATA_W     : width of each register
//   ADDR_W     : register-number width
//   NREG       : number of registers (2**ADDR_W)
//   WR_COUNT_W : width of the saturating accepted-write counter
//   clr_state_t: clear-sequencer FSM encoding
package regfile_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int NREG       = 32;
    localparam int WR_COUNT_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: the FSM plus the sweep counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_req     : single-cycle request to start a sweep (ignored while sweeping)
//   clr_busy    : sweep in progress (state == CLEAR, a registered value)
//   clr_en      : clear the register addressed by clr_addr this cycle
//   clr_addr    : register being cleared this cycle
//   state_dbg   : current FSM state, for checkers
module regfile_clear_seq #(
    parameter int NREG   = regfile_pkg::NREG,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    clr_en,
    output logic [ADDR_W-1:0]       clr_addr,
    output regfile_pkg::clr_state_t state_dbg
);
    import regfile_pkg::*;

    clr_state_t        state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Register 0 is never stored, so the sweep starts at 1 and ends at NREG-1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                if (cnt == ADDR_W'(NREG - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + ADDR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign clr_busy  = (state == CLEAR);
    assign clr_en    = (state == CLEAR);
    assign clr_addr  = cnt;
    assign state_dbg = state;

endmodule

// File: rtl/regfile_bank.sv
// Storage stage of the CPU register file: NREG x DATA_W registers with one
// handshaked write port, a bulk-clear sequencer, and a flat contents bus that
// feeds the downstream read-select muxes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_valid   : write request present
//   wr_ready   : block can accept a write this cycle
//   wr_addr    : destination register number
//   wr_data    : write data
//   clr_req    : single-cycle request to zero all registers
//   clr_busy   : clear sweep in progress
//   q_flat     : register i at bits [DATA_W*i +: DATA_W]; register 0 reads 0
//   wr_count   : accepted writes to registers 1..NREG-1, saturating
// Handshake: a write is accepted on a rising edge where wr_valid && wr_ready;
// the producer holds wr_addr/wr_data until then, and the value is visible on
// q_flat right after that edge.
module regfile_bank #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int NREG   = regfile_pkg::NREG,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic                               clr_req,
    output logic                               clr_busy,
    output logic [NREG*DATA_W-1:0]             q_flat,
    output logic [regfile_pkg::WR_COUNT_W-1:0] wr_count
);
    import regfile_pkg::*;

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    clr_state_t        clr_state;
    logic              wr_fire;
    logic [NREG-1:0]   wr_sel;
    logic [NREG-1:0]   clr_sel;

    regfile_clear_seq #(
        .NREG   (NREG),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr),
        .state_dbg (clr_state)
    );

    // rst_n is folded in so ready is low for the whole reset window.
    assign wr_ready = (clr_state == IDLE) && rst_n;
    assign wr_fire  = wr_valid && wr_ready;

    // One-hot decodes; bit 0 is forced low so register 0 is never stored.
    always_comb begin
        wr_sel           = '0;
        clr_sel          = '0;
        wr_sel[wr_addr]  = wr_fire;
        clr_sel[clr_addr] = clr_en;
        wr_sel[0]        = 1'b0;
        clr_sel[0]       = 1'b0;
    end

    assign q_flat[DATA_W-1:0] = '0;

    // Writes only fire in IDLE and clears only in CLEAR, so the two selects
    // are never active together for the same register.
    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic [DATA_W-1:0] r;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r <= '0;
            end else if (clr_sel[i]) begin
                r <= '0;
            end else if (wr_sel[i]) begin
                r <= wr_data;
            end
        end
        assign q_flat[DATA_W*i +: DATA_W] = r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (wr_fire && (wr_addr != '0) && (wr_count != '1)) begin
            wr_count <= wr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_bank.sv
module tb_regfile_bank;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int ADDR_W = 5;

    logic                   clk;
    logic                   rst_n;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   clr_req;
    logic                   clr_busy;
    logic [NREG*DATA_W-1:0] q_flat;
    logic [15:0]            wr_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    regfile_bank dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .q_flat   (q_flat),
        .wr_count (wr_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] slice(input int i);
        return q_flat[DATA_W*i +: DATA_W];
    endfunction

    // ---------------- drivers ----------------
    // Starts and ends on a negedge; ends just after the accepting edge.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit done = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int t = 0; t < 64 && !done; t++) begin
            if (wr_ready) begin
                @(posedge clk);
                done = 1;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        if (!done) check_eq("write_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 64 && clr_busy; t++) @(negedge clk);
        check_eq("idle_timeout", clr_busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        clr_req  = 1'b0;

        // Reset then idle
        repeat (3) @(negedge clk);
        check_eq("rst_q_flat_zero", |q_flat, 0);
        check_eq("rst_wr_count", wr_count, 0);
        check_eq("rst_clr_busy", clr_busy, 0);
        check_eq("rst_wr_ready", wr_ready, 0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_wr_ready", wr_ready, 1);
        @(negedge clk);

        // Basic write/readback
        exp_q.push_back(32'hDEADBEEF);
        do_write(5'd5, 32'hDEADBEEF);
        check_eq("r5_readback", slice(5), exp_q.pop_front());
        exp_q.push_back(32'h12345678);
        do_write(5'd31, 32'h12345678);
        check_eq("r31_readback", slice(31), exp_q.pop_front());
        check_eq("r5_kept", slice(5), 32'hDEADBEEF);
        check_eq("count_after_2", wr_count, 2);

        // Register zero
        do_write(5'd0, 32'hFFFFFFFF);
        check_eq("r0_stays_zero", slice(0), 0);
        check_eq("count_r0_unchanged", wr_count, 2);

        // Clear sweep
        for (int i = 1; i < NREG; i++) do_write(ADDR_W'(i), 32'h01010101 * i);
        check_eq("count_after_fill", wr_count, 33);
        check_eq("r17_filled", slice(17), 32'h11111111);
        clr_req = 1'b1;
        @(negedge clk);                      // after clear-start edge
        clr_req  = 1'b0;
        wr_valid = 1'b1;                     // pending write held throughout
        wr_addr  = 5'd9;
        wr_data  = 32'hCAFEF00D;
        for (int k = 0; k < 31; k++) begin
            check_eq($sformatf("sweep_busy_%0d", k), clr_busy, 1);
            check_eq($sformatf("sweep_ready_%0d", k), wr_ready, 0);
            if (k >= 1) check_eq($sformatf("sweep_r%0d_zero", k), slice(k), 0);
            check_eq($sformatf("sweep_r%0d_held", k + 1), slice(k + 1), 32'h01010101 * (k + 1));
            clr_req = (k == 5);              // a request mid-sweep is ignored
            @(negedge clk);
        end
        clr_req = 1'b0;
        check_eq("sweep_busy_fell", clr_busy, 0);
        check_eq("sweep_ready_back", wr_ready, 1);
        check_eq("sweep_all_zero", |q_flat, 0);
        @(negedge clk);                      // pending write accepted on this edge
        wr_valid = 1'b0;
        check_eq("pending_write", slice(9), 32'hCAFEF00D);
        check_eq("count_after_pending", wr_count, 34);
        check_eq("no_restart", clr_busy, 0);

        // Same-cycle clear and write
        wr_valid = 1'b1;
        wr_addr  = 5'd3;
        wr_data  = 32'hAAAA5555;
        clr_req  = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("same_r3_hold_%0d", k), slice(3), 32'hAAAA5555);
            @(negedge clk);
        end
        check_eq("same_r3_cleared", slice(3), 0);
        check_eq("same_count", wr_count, 35);
        wait_idle();

        // Reset mid-clear
        do_write(5'd20, 32'h5A5A5A5A);
        check_eq("r20_before_reset", slice(20), 32'h5A5A5A5A);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (9) @(negedge clk);           // sweep counter now at 10
        check_eq("midclr_busy", clr_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midclr_q_zero", |q_flat, 0);
        check_eq("midclr_busy_off", clr_busy, 0);
        check_eq("midclr_ready_off", wr_ready, 0);
        check_eq("midclr_count", wr_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("after_rst_idle", clr_busy, 0);
        check_eq("after_rst_ready", wr_ready, 1);

        // Saturation: 65540 back-to-back writes to r7
        wr_valid = 1'b1;
        wr_addr  = 5'd7;
        wr_data  = 32'h77777777;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check_eq("sat_fffe", wr_count, 16'hFFFE);
        @(posedge clk);
        @(negedge clk);
        check_eq("sat_ffff", wr_count, 16'hFFFF);
        repeat (5) @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        check_eq("sat_no_wrap", wr_count, 16'hFFFF);
        check_eq("sat_r7", slice(7), 32'h77777777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound in case a wait above never resolves.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
